// File: rtl/uart_dumper.sv
// uart_dumper: reads WORD_COUNT 32-bit words starting at BASE_ADDRESS and
// streams them out over an 8N1 UART, least significant byte first, with
// each byte sent LSB first.
// Optional build macro UART_DUMPER_MARKER_EN: when defined, four 0xFF bytes
// are sent after the last word as an end-of-dump marker.
module uart_dumper #(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          WORD_COUNT   = 256,
  parameter logic [31:0] BASE_ADDRESS = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_dump,
  output logic [31:0] read_byte_address,
  output logic        read_en,
  input  logic [31:0] read_data,
  output logic        tx_serial,
  output logic        busy,
  output logic        done
);

  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [16:0] WORDS    = 17'(WORD_COUNT);

`ifdef UART_DUMPER_MARKER_EN
  typedef enum logic [2:0] {IDLE, READ_REQ, READ_WAIT, SEND, MARKER, FINISH} state_t;
`else
  typedef enum logic [2:0] {IDLE, READ_REQ, READ_WAIT, SEND, FINISH} state_t;
`endif

  state_t      state;
  logic [15:0] word_idx;
  logic [31:0] word_reg;
  logic [1:0]  byte_sel;
  logic [3:0]  bit_cnt;   // frame position: 0 start, 1..8 data, 9 stop
  logic [15:0] cyc_cnt;   // cycles spent in the current bit
  logic [7:0]  cur_byte;
  logic [16:0] next_idx;
  logic        more_words;

  // Line level for frame position pos of byte b.
  function automatic logic frame_level(input logic [7:0] b, input logic [3:0] pos);
    if (pos == 4'd0)      frame_level = 1'b0;
    else if (pos >= 4'd9) frame_level = 1'b1;
    else                  frame_level = b[3'(pos - 4'd1)];
  endfunction

  // Select the byte being framed and decide whether another word follows.
  always_comb begin
    cur_byte = word_reg[7:0];
    case (byte_sel)
      2'd1:    cur_byte = word_reg[15:8];
      2'd2:    cur_byte = word_reg[23:16];
      2'd3:    cur_byte = word_reg[31:24];
      default: cur_byte = word_reg[7:0];
    endcase
`ifdef UART_DUMPER_MARKER_EN
    if (state == MARKER) cur_byte = 8'hFF;
`endif
    next_idx   = {1'b0, word_idx} + 17'd1;
    more_words = (next_idx < WORDS);
  end

  // Capture the memory word while waiting on the read; data path, no reset.
  always_ff @(posedge clk) begin
    if (state == READ_WAIT) word_reg <= read_data;
  end

  // Dump sequencer: all outputs registered so tx_serial is glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      word_idx          <= 16'd0;
      byte_sel          <= 2'd0;
      bit_cnt           <= 4'd0;
      cyc_cnt           <= 16'd0;
      tx_serial         <= 1'b1;
      busy              <= 1'b0;
      done              <= 1'b0;
      read_en           <= 1'b0;
      read_byte_address <= 32'd0;
    end else begin
      read_en <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start_dump) begin
            busy     <= 1'b1;
            word_idx <= 16'd0;
            if (WORDS == 17'd0) begin
`ifdef UART_DUMPER_MARKER_EN
              state     <= MARKER;
              byte_sel  <= 2'd0;
              bit_cnt   <= 4'd0;
              cyc_cnt   <= 16'd0;
              tx_serial <= 1'b0;
`else
              state <= FINISH;
              done  <= 1'b1;
`endif
            end else begin
              state             <= READ_REQ;
              read_en           <= 1'b1;
              read_byte_address <= BASE_ADDRESS;
            end
          end
        end
        READ_REQ: state <= READ_WAIT;
        READ_WAIT: begin
          state     <= SEND;
          byte_sel  <= 2'd0;
          bit_cnt   <= 4'd0;
          cyc_cnt   <= 16'd0;
          tx_serial <= 1'b0;
        end
`ifdef UART_DUMPER_MARKER_EN
        SEND, MARKER: begin
`else
        SEND: begin
`endif
          if (cyc_cnt != BIT_LAST) begin
            cyc_cnt <= cyc_cnt + 16'd1;
          end else begin
            cyc_cnt <= 16'd0;
            if (bit_cnt != 4'd9) begin
              bit_cnt   <= bit_cnt + 4'd1;
              tx_serial <= frame_level(cur_byte, bit_cnt + 4'd1);
            end else if (byte_sel != 2'd3) begin
              // Back-to-back bytes: next start bit follows the stop bit directly.
              byte_sel  <= byte_sel + 2'd1;
              bit_cnt   <= 4'd0;
              tx_serial <= 1'b0;
            end else begin
              byte_sel  <= 2'd0;
              bit_cnt   <= 4'd0;
              tx_serial <= 1'b1;
              if (state == SEND && more_words) begin
                // READ_REQ and READ_WAIT give the two idle-high cycles between words.
                state             <= READ_REQ;
                word_idx          <= next_idx[15:0];
                read_en           <= 1'b1;
                read_byte_address <= BASE_ADDRESS + {14'd0, next_idx[15:0], 2'b00};
              end
`ifdef UART_DUMPER_MARKER_EN
              else if (state == SEND) begin
                state     <= MARKER;
                tx_serial <= 1'b0;
              end
`endif
              else begin
                state <= FINISH;
                done  <= 1'b1;
              end
            end
          end
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_dumper.sv
// Scoreboard bench for uart_dumper: stimulus pushes expected read addresses
// and UART bytes; independent monitors decode the line and pop/compare.
module tb_uart_dumper;

  localparam int CPB = 4;

  typedef struct {
    logic [7:0] b;
    int         gap;   // idle-high cycles required before the start bit, -1 = any
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_dump = 1'b0;
  logic        start0 = 1'b0;
  logic [31:0] addr, addr0;
  logic [31:0] rdata = 32'd0;
  logic [31:0] rdata0 = 32'd0;
  logic        read_en, tx, busy, done;
  logic        read_en0, tx0, busy0, done0;
  logic [31:0] mem [2];

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int rd0_cnt = 0;
  int tx0_low = 0;

  exp_t        byte_q[$];
  logic [31:0] addr_q[$];

  always #5 clk = ~clk;

  uart_dumper #(.CLKS_PER_BIT(CPB), .WORD_COUNT(2), .BASE_ADDRESS(32'h100)) dut (
    .clk(clk), .rst(rst), .start_dump(start_dump),
    .read_byte_address(addr), .read_en(read_en), .read_data(rdata),
    .tx_serial(tx), .busy(busy), .done(done)
  );

  uart_dumper #(.CLKS_PER_BIT(CPB), .WORD_COUNT(0), .BASE_ADDRESS(32'h100)) dut0 (
    .clk(clk), .rst(rst), .start_dump(start0),
    .read_byte_address(addr0), .read_en(read_en0), .read_data(rdata0),
    .tx_serial(tx0), .busy(busy0), .done(done0)
  );

  // Memory model: word available on the cycle after read_en.
  always @(posedge clk) begin
    if (read_en === 1'b1)
      rdata <= (addr == 32'h100) ? mem[0] : (addr == 32'h104) ? mem[1] : 32'hBAD0_BAD0;
  end

  // UART decoder monitor.
  int         s = -1;
  int         idle_cnt = -1;
  int         gap_seen = -1;
  logic [9:0] bits = '0;
  logic       glitch = 1'b0;

  task automatic check_frame();
    exp_t e;
    logic ok;
    n_cmp++;
    if (byte_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_byte: got %02h, no byte required", bits[8:1]);
    end else begin
      e = byte_q.pop_front();
      ok = (bits[0] == 1'b0) && (bits[9] == 1'b1) && (bits[8:1] == e.b) && !glitch &&
           (e.gap < 0 || e.gap == gap_seen);
      if (!ok)
        $display("FAIL uart_byte: got %02h start=%0b stop=%0b glitch=%0b gap=%0d, required %02h start=0 stop=1 glitch=0 gap=%0d",
                 bits[8:1], bits[0], bits[9], glitch, gap_seen, e.b, e.gap);
      if (!ok) n_err++;
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      s = -1;
      idle_cnt = -1;
    end else if (s < 0) begin
      if (tx === 1'b0) begin
        bits[0]  = 1'b0;
        glitch   = 1'b0;
        gap_seen = idle_cnt;
        s = 1;
      end else if (idle_cnt >= 0) begin
        idle_cnt++;
      end
    end else begin
      if (s % CPB == 0) bits[s / CPB] = tx;
      else if (tx !== bits[s / CPB]) glitch = 1'b1;
      s++;
      if (s == 10 * CPB) begin
        check_frame();
        s = -1;
        idle_cnt = 0;
      end
    end
  end

  // Read address monitor.
  always @(negedge clk) begin
    if (!rst && read_en === 1'b1) begin
      n_cmp++;
      if (addr_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_read: address %08h, no read required", addr);
      end else if (addr !== addr_q[0]) begin
        n_err++;
        $display("FAIL read_address: got %08h, required %08h", addr, addr_q[0]);
        void'(addr_q.pop_front());
      end else begin
        void'(addr_q.pop_front());
      end
    end
  end

  // Done monitor: done must coincide with busy and follow the final byte.
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      done_cnt++;
      n_cmp++;
      if (busy !== 1'b1 || byte_q.size() != 0) begin
        n_err++;
        $display("FAIL done_pulse: busy=%0b bytes_pending=%0d, required busy=1 bytes_pending=0",
                 busy, byte_q.size());
      end
    end
  end

  // Zero-word instance activity counters.
  always @(negedge clk) begin
    if (!rst) begin
      if (read_en0 === 1'b1) rd0_cnt++;
      if (tx0 !== 1'b1) tx0_low++;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic push_word(input logic [31:0] w, input int first_gap);
    byte_q.push_back('{w[7:0],   first_gap});
    byte_q.push_back('{w[15:8],  0});
    byte_q.push_back('{w[23:16], 0});
    byte_q.push_back('{w[31:24], 0});
  endtask

  task automatic push_dump(input logic [31:0] w0, input logic [31:0] w1);
    mem[0] = w0;
    mem[1] = w1;
    addr_q.push_back(32'h100);
    addr_q.push_back(32'h104);
    push_word(w0, -1);
    push_word(w1, 2);
`ifdef UART_DUMPER_MARKER_EN
    push_word(32'hFFFF_FFFF, 0);
`endif
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start_dump = 1'b1;
    @(negedge clk);
    start_dump = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int start_cnt;
    int k;
    start_cnt = done_cnt;
    k = 0;
    while (done_cnt == start_cnt && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (done_cnt == start_cnt) begin
      n_err++;
      $display("FAIL %s_timeout: no done within %0d cycles, required one done pulse", name, budget);
    end
  endtask

  int lvl_a5[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

  initial begin
    int d0;
    int k;
    logic ok;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_read_en", {31'd0, read_en}, 32'd0);
    check("reset_address", addr, 32'd0);

    // Basic two-word dump; start asserted together with reset release.
    push_dump(32'h1234_5678, 32'hDEAD_BEEF);
    d0 = done_cnt;
    #2;
    rst = 1'b0;
    start_dump = 1'b1;
    @(negedge clk);
    start_dump = 1'b0;
    check("start_after_reset_busy", {31'd0, busy}, 32'd1);
    wait_done("dump1", 1000);
    repeat (5) @(negedge clk);
    check("dump1_done_count", done_cnt - d0, 32'd1);
    check("dump1_idle_tx", {31'd0, tx}, 32'd1);
    check("dump1_idle_busy", {31'd0, busy}, 32'd0);

    // Bit-level frame for 0xA5.
    push_dump(32'h3C5A_C3A5, 32'h0102_8001);
    d0 = done_cnt;
    pulse_start();
    k = 0;
    while (tx !== 1'b0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    for (int b = 0; b < 10; b++) begin
      ok = 1'b1;
      for (int c = 0; c < CPB; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        if (tx !== lvl_a5[b][0]) ok = 1'b0;
      end
      n_cmp++;
      if (!ok) begin
        n_err++;
        $display("FAIL a5_bit%0d: level not held at %0d for %0d cycles (last seen %0b)",
                 b, lvl_a5[b], CPB, tx);
      end
    end
    wait_done("dump_a5", 1000);
    repeat (5) @(negedge clk);
    check("dump_a5_done_count", done_cnt - d0, 32'd1);

    // start_dump pulsed during byte 1 is ignored and not queued.
    push_dump(32'h1234_5678, 32'hDEAD_BEEF);
    d0 = done_cnt;
    pulse_start();
    repeat (50) @(negedge clk);
    start_dump = 1'b1;
    @(negedge clk);
    start_dump = 1'b0;
    wait_done("dump_ignore", 1000);
    repeat (10) @(negedge clk);
    check("ignore_done_count", done_cnt - d0, 32'd1);
    check("start_not_queued_busy", {31'd0, busy}, 32'd0);

    // Reset in the middle of a data bit of word 0.
    mem[0] = 32'h1234_5678;
    addr_q.push_back(32'h100);
    d0 = done_cnt;
    pulse_start();
    repeat (20) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_tx", {31'd0, tx}, 32'd1);
    check("async_reset_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
    check("abort_done_count", done_cnt - d0, 32'd0);
    push_dump(32'hCAFE_F00D, 32'h0BAD_BEEF);
    d0 = done_cnt;
    pulse_start();
    wait_done("dump_restart", 1000);
    repeat (5) @(negedge clk);
    check("restart_done_count", done_cnt - d0, 32'd1);

`ifndef UART_DUMPER_MARKER_EN
    // Zero-word instance: straight to FINISH.
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    check("wc0_done_pulse", {30'd0, done0, busy0}, 32'd3);
    @(negedge clk);
    check("wc0_after_done", {30'd0, done0, busy0}, 32'd0);
    repeat (5) @(negedge clk);
    check("wc0_read_en_count", rd0_cnt, 32'd0);
    check("wc0_tx_low_count", tx0_low, 32'd0);
`endif

    check("bytes_outstanding", byte_q.size(), 32'd0);
    check("reads_outstanding", addr_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
